xvc_jtag_shifter: RTL and testbench
===================================

Name: xvc_jtag_shifter

Overview:
- Executes one XVC "shift:" command segment on the physical JTAG pins.
- Takes a bit count plus TMS/TDI vectors from the PCIe-side register block.
- Generates TCK, drives TMS/TDI, captures TDO and returns the TDO vector with a done pulse.
- Sits between the pciebd AXI register slice and the FPGA JTAG header pins, in the clk100 domain.

Parameters:
- WORD_W, 32, width of the TMS/TDI/TDO vectors; maximum bits per command.
- TCK_DIV, 4, clk100 cycles per TCK half-period. Minimum 1; TCK = clk100/(2*TCK_DIV).

Ports:
- clk100 input 1: system clock, all logic on rising edge.
- reset input 1: asynchronous, active-high reset.
- start input 1: single-cycle command strobe; accepted only when busy=0.
- length input $clog2(WORD_W+1): number of bits to shift, 0..WORD_W.
- tms_vec input WORD_W: TMS bits, LSB shifted first.
- tdi_vec input WORD_W: TDI bits, LSB shifted first.
- busy output 1: high from the cycle after start is accepted until done.
- done output 1: one-cycle pulse; tdo_vec is valid from this cycle.
- tdo_vec output WORD_W: captured TDO; bit i is sampled during TCK cycle i; bits >= length are 0.
- tck output 1: JTAG clock.
- tms output 1: JTAG TMS.
- tdi output 1: JTAG TDI.
- tdo input 1: JTAG TDO from the target.

Behaviour:
- Reset values (asynchronous): busy=0, done=0, tdo_vec=0, tck=0, tms=1, tdi=0, FSM=IDLE.
- States and transitions:
  - IDLE: on start with length>0, latch length, tms_vec and tdi_vec; clear tdo_vec; drive tms=tms_vec[0], tdi=tdi_vec[0], tck=0; go to LOW.
  - IDLE: on start with length=0, go straight to DONE; tdo_vec=0; no TCK edges.
  - LOW: tck=0 for TCK_DIV cycles, then tck=1 and go to HIGH.
  - HIGH: tck=1 for TCK_DIV cycles. On the last HIGH cycle, capture tdo into tdo_vec[bit_idx].
  - HIGH, then: if bit_idx==length-1, tck=0 and go to DONE. Otherwise bit_idx+1, tck=0, tms/tdi take the next bit (setup on the falling edge), and go to LOW.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- tms/tdi keep their last-shifted value after completion (TAP state is preserved).
- Counters:
  - Half-period counter is $clog2(TCK_DIV) wide (min 1 bit) and reloads on every phase change.
  - bit_idx is $clog2(WORD_W) wide.
  - length > WORD_W is saturated to WORD_W.
- Latency:
  - start accepted in cycle 0 with length N>0: done in cycle 2*N*TCK_DIV+1.
  - length 0: done in cycle 1.
- start while busy (LOW/HIGH/DONE) is ignored; the latched vectors do not change.
- start in the same cycle as the DONE pulse is ignored; a new command needs busy=0 in IDLE.
- reset mid-shift aborts immediately to reset values. A partial tdo_vec is discarded and no done pulse is issued.

Optional Feature:
- Macro: XVC_TDO_SYNC_EN.
- Defined:
  - tdo passes through a 2-flop synchronizer (reset to 0) before capture.
  - Capture moves 2 clk100 cycles after the rising TCK edge. The HIGH phase is extended to max(TCK_DIV,3) cycles so capture still lands before the falling edge.
  - Latency becomes 2*N*TCK_DIV_EFF+1.
- Undefined: tdo is sampled directly on the last HIGH cycle with no extra flops.

Decomposition:
- Package xvc_pkg:
  - typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} shift_state_t.
  - localparam XVC_WORD_W=32.
  - Function tck_div_eff(TCK_DIV), used for the synchronized variant.
- One natural sub-module: xvc_tck_gen (half-period counter plus phase toggle, emitting phase_end strobes).
- FSM and shift registers stay in xvc_jtag_shifter.

Test Plan:
- TCK_DIV=4, length=5, tms_vec=0x1F, tdi_vec=0 (TAP reset) -> tms=1 on all 5 TCK rising edges; exactly 5 tck pulses each 4 cycles high and 4 low; done at cycle 41.
- length=32, tdi_vec=0xDEADBEEF, TDO loopback model (tdo=tdi registered on rising TCK) -> tdo_vec=0xDEADBEEF; done pulse exactly 1 cycle wide; busy high cycles 1..256.
- length=0 -> no tck edge; done at cycle 1; tdo_vec=0.
- length=3 with tdo tied 1 -> tdo_vec=0x00000007; upper bits 0.
- start re-pulsed during busy with different vectors -> ignored; output matches the first command; single done.
- reset asserted at cycle 20 of a 32-bit shift -> outputs go to reset values asynchronously (tms=1, tck=0); no done. A following start runs cleanly from bit 0.

Source files
------------

// File: rtl/xvc_pkg.sv
// Shared types and helpers for the XVC JTAG shift engine.
package xvc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } shift_state_t;

    localparam int XVC_WORD_W = 32;

    // With a 2-flop TDO synchronizer the HIGH phase needs at least 3 cycles
    // so the synchronized sample lands before the falling TCK edge.
    function automatic int tck_div_eff(input int tck_div);
        return (tck_div < 3) ? 3 : tck_div;
    endfunction

endpackage

// File: rtl/xvc_tck_gen.sv
// TCK half-period timer: down-counter with terminal-count strobe and phase toggle.
module xvc_tck_gen
    import xvc_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk100,
    input  logic reset,
    input  logic run,
    output logic phase,
    output logic phase_end
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign phase_end = run && (cnt == '0);

    // Phase is held low while idle so TCK parks low between commands.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            cnt   <= RELOAD;
            phase <= 1'b0;
        end else if (!run) begin
            cnt   <= RELOAD;
            phase <= 1'b0;
        end else if (phase_end) begin
            cnt   <= RELOAD;
            phase <= ~phase;
        end else begin
            cnt   <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/xvc_jtag_shifter.sv
// Executes one XVC shift segment on the JTAG pins and returns the captured TDO vector.
// Optional macro XVC_TDO_SYNC_EN adds a 2-flop TDO synchronizer and stretches the TCK phases.
module xvc_jtag_shifter
    import xvc_pkg::*;
#(
    parameter int WORD_W  = XVC_WORD_W,
    parameter int TCK_DIV = 4
) (
    input  logic                       clk100,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(WORD_W+1)-1:0] length,
    input  logic [WORD_W-1:0]          tms_vec,
    input  logic [WORD_W-1:0]          tdi_vec,
    output logic                       busy,
    output logic                       done,
    output logic [WORD_W-1:0]          tdo_vec,
    output logic                       tck,
    output logic                       tms,
    output logic                       tdi,
    input  logic                       tdo
);

    localparam int LW = $clog2(WORD_W + 1);
    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic tdo_cap;

`ifdef XVC_TDO_SYNC_EN
    localparam int DIV_EFF = tck_div_eff(TCK_DIV);

    logic tdo_meta;
    logic tdo_sync;

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            tdo_meta <= 1'b0;
            tdo_sync <= 1'b0;
        end else begin
            tdo_meta <= tdo;
            tdo_sync <= tdo_meta;
        end
    end

    assign tdo_cap = tdo_sync;
`else
    localparam int DIV_EFF = TCK_DIV;

    assign tdo_cap = tdo;
`endif

    shift_state_t      state, state_nx;
    logic [LW-1:0]     len_sat;
    logic [LW-1:0]     len_q;
    logic [IW-1:0]     bit_idx;
    logic [WORD_W-1:0] tms_sh, tdi_sh;
    logic [WORD_W-1:0] tms_nx, tdi_nx;
    logic              last_bit;
    logic              phase_end;
    logic              tck_phase;

    assign len_sat  = (length > LW'(WORD_W)) ? LW'(WORD_W) : length;
    assign last_bit = (LW'(bit_idx) == (len_q - LW'(1)));
    assign tms_nx   = tms_sh >> 1;
    assign tdi_nx   = tdi_sh >> 1;

    xvc_tck_gen #(
        .DIV (DIV_EFF)
    ) u_tck_gen (
        .clk100    (clk100),
        .reset     (reset),
        .run       (busy),
        .phase     (tck_phase),
        .phase_end (phase_end)
    );

    assign tck = tck_phase;

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (len_sat == '0) ? DONE : LOW;
            LOW:  if (phase_end) state_nx = HIGH;
            HIGH: if (phase_end) state_nx = last_bit ? DONE : LOW;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == LOW) || (state == HIGH);
        done = (state == DONE);
    end

    // Next TMS/TDI bit is set up on the falling TCK edge; both hold after completion.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            len_q   <= '0;
            bit_idx <= '0;
            tms_sh  <= '0;
            tdi_sh  <= '0;
            tdo_vec <= '0;
            tms     <= 1'b1;
            tdi     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tdo_vec <= '0;
                        if (len_sat != '0) begin
                            len_q   <= len_sat;
                            bit_idx <= '0;
                            tms_sh  <= tms_vec;
                            tdi_sh  <= tdi_vec;
                            tms     <= tms_vec[0];
                            tdi     <= tdi_vec[0];
                        end
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        tdo_vec[bit_idx] <= tdo_cap;
                        if (!last_bit) begin
                            bit_idx <= bit_idx + IW'(1);
                            tms_sh  <= tms_nx;
                            tdi_sh  <= tdi_nx;
                            tms     <= tms_nx[0];
                            tdi     <= tdi_nx[0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xvc_jtag_shifter.sv
// Scoreboard bench for xvc_jtag_shifter: expected TDO vector and done cycle queued per command.
module tb_xvc_jtag_shifter;

    localparam int W   = 32;
    localparam int DIV = 4;

    logic          clk100 = 1'b0;
    logic          rst;
    logic          start;
    logic [5:0]    length;
    logic [W-1:0]  tms_vec;
    logic [W-1:0]  tdi_vec;
    logic          busy;
    logic          done;
    logic [W-1:0]  tdo_vec;
    logic          tck;
    logic          tms;
    logic          tdi;
    logic          tdo;

    int            tdo_sel;
    logic          tdo_lb;

    typedef struct {
        logic [W-1:0] tdo;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    xvc_jtag_shifter #(
        .WORD_W  (W),
        .TCK_DIV (DIV)
    ) dut (
        .clk100  (clk100),
        .reset   (rst),
        .start   (start),
        .length  (length),
        .tms_vec (tms_vec),
        .tdi_vec (tdi_vec),
        .busy    (busy),
        .done    (done),
        .tdo_vec (tdo_vec),
        .tck     (tck),
        .tms     (tms),
        .tdi     (tdi),
        .tdo     (tdo)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc++;

    // Target model: loopback returns TDI registered on the rising TCK edge.
    always @(posedge tck or posedge rst) begin
        if (rst) tdo_lb <= 1'b0;
        else     tdo_lb <= tdi;
    end

    assign tdo = (tdo_sel == 2) ? tdo_lb : (tdo_sel == 1);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk100) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tdo_vec", tdo_vec, e.tdo);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic logic [W-1:0] lmask(input int n);
        logic [W-1:0] one;
        one = 1;
        return (n >= W) ? '1 : ((one << n) - 1);
    endfunction

    task automatic run_cmd(input int len, input logic [W-1:0] tmsv, input logic [W-1:0] tdiv,
                           input int mode, input logic [W-1:0] exp_tdo,
                           input int repulse_at, input bit pulse_on_done);
        int           eff;
        int           n;
        int           busy_cnt;
        int           rises;
        int           hi_run;
        int           hw_bad;
        logic         prev_tck;
        logic         busy1;
        logic [W-1:0] tms_seen;
        logic [W-1:0] tdi_seen;
        eff = (len > W) ? W : len;
        tdo_sel = mode;
        @(negedge clk100);
        start   = 1'b1;
        length  = 6'(len);
        tms_vec = tmsv;
        tdi_vec = tdiv;
        sb.push_back('{exp_tdo, cyc + 2 * eff * DIV + 1});
        @(negedge clk100);
        start   = 1'b0;
        tms_vec = ~tmsv;
        tdi_vec = ~tdiv;
        n = 0; busy_cnt = 0; rises = 0; hi_run = 0; hw_bad = 0;
        prev_tck = 1'b0; busy1 = busy; tms_seen = '0; tdi_seen = '0;
        forever begin
            if (busy) busy_cnt++;
            if (tck && !prev_tck) begin
                if (rises < W) begin
                    tms_seen[rises] = tms;
                    tdi_seen[rises] = tdi;
                end
                rises++;
                hi_run = 1;
            end else if (tck) begin
                hi_run++;
            end else if (prev_tck) begin
                if (hi_run != DIV) hw_bad++;
            end
            prev_tck = tck;
            if (done || n >= 2000) break;
            if (n == repulse_at) begin
                start   = 1'b1;
                length  = 6'd4;
                tms_vec = 32'hFFFF_FFFF;
                tdi_vec = 32'h0000_003C;
            end else begin
                start = 1'b0;
            end
            @(negedge clk100);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        chk("busy_first_cycle", busy1, (eff > 0));
        chk("busy_cycles", busy_cnt, 2 * eff * DIV);
        chk("tck_rises", rises, eff);
        chk("tck_high_width", hw_bad, 0);
        chk("tms_on_rise", tms_seen, tmsv & lmask(eff));
        chk("tdi_on_rise", tdi_seen, tdiv & lmask(eff));
        if (pulse_on_done) begin
            start   = 1'b1;
            length  = 6'd2;
            tms_vec = '1;
            tdi_vec = '1;
            @(negedge clk100);
            start = 1'b0;
            chk("start_on_done_ignored", busy, 1'b0);
            repeat (3) @(negedge clk100);
            chk("idle_after_done", busy, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; length = '0; tms_vec = '0; tdi_vec = '0; tdo_sel = 0;
        repeat (3) @(negedge clk100);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tdo_vec", tdo_vec, 32'h0);
        chk("rst_tck", tck, 1'b0);
        chk("rst_tms", tms, 1'b1);
        chk("rst_tdi", tdi, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk100);

        run_cmd(5, 32'h0000_001F, 32'h0, 0, 32'h0, -1, 1'b0);
        chk("tms_held_after", tms, 1'b1);
        run_cmd(32, 32'h8000_0001, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, -1, 1'b0);
        run_cmd(0, 32'h0, 32'hFFFF_FFFF, 1, 32'h0, -1, 1'b0);
        run_cmd(3, 32'h0000_0005, 32'h0, 1, 32'h0000_0007, -1, 1'b0);
        run_cmd(8, 32'h0000_0096, 32'h0000_00A5, 2, 32'h0000_00A5, 10, 1'b1);
        run_cmd(40, 32'h0F0F_0F0F, 32'h1234_5678, 2, 32'h1234_5678, -1, 1'b0);

        tdo_sel = 2;
        @(negedge clk100);
        start = 1'b1; length = 6'd32; tms_vec = '0; tdi_vec = 32'hFFFF_0000;
        @(negedge clk100);
        start = 1'b0;
        repeat (19) @(negedge clk100);
        #2 rst = 1'b1;
        #1;
        chk("abort_tms", tms, 1'b1);
        chk("abort_tck", tck, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_tdo_vec", tdo_vec, 32'h0);
        repeat (2) @(negedge clk100);
        rst = 1'b0;
        repeat (5) @(negedge clk100);
        chk("abort_idle", busy, 1'b0);

        run_cmd(32, 32'h0000_0003, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, -1, 1'b0);

        repeat (4) @(negedge clk100);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
